// File: rtl/csi2_pkt_hdr_enc_if.sv
// Request, payload and output stream signals of the CSI-2 packet header encoder.
// Inject ports exist only when CSI2_HDR_ERR_INJECT_EN is defined.
interface csi2_pkt_hdr_enc_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [5:0]  dt_i;
  logic [1:0]  vc_i;
  logic [15:0] wc_i;
  logic [31:0] pl_data_i;
  logic        pl_valid_i;
  logic        pl_ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
`ifdef CSI2_HDR_ERR_INJECT_EN
  logic        inject_i;
  logic [4:0]  inject_bit_i;
`endif

  modport slave (
    input  req_valid_i, dt_i, vc_i, wc_i, pl_data_i, pl_valid_i, ready_i,
`ifdef CSI2_HDR_ERR_INJECT_EN
    input  inject_i, inject_bit_i,
`endif
    output req_ready_o, pl_ready_o, data_o, valid_o, last_o
  );

  modport master (
    output req_valid_i, dt_i, vc_i, wc_i, pl_data_i, pl_valid_i, ready_i,
`ifdef CSI2_HDR_ERR_INJECT_EN
    output inject_i, inject_bit_i,
`endif
    input  req_ready_o, pl_ready_o, data_o, valid_o, last_o
  );
endinterface

// File: rtl/csi2_pkt_hdr_enc.sv
// CSI-2 TX packet header encoder: header word with 6-bit ECC, then the payload stream.
// Optional header bit-flip injection under CSI2_HDR_ERR_INJECT_EN.
module csi2_pkt_hdr_enc (
  input  logic                 clk_i,
  input  logic                 rst_i,
  csi2_pkt_hdr_enc_if.slave    bus
);
  typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

  state_t      state_q, state_d;
  logic [14:0] rem_q, rem_d;
  logic [1:0]  wc_lo_q, wc_lo_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  logic        slot_free, req_acc, pl_acc;
  logic [16:0] wc_sum;
  logic [14:0] words;
  logic [23:0] hdr_lo;
  logic [31:0] hdr;
  logic [31:0] pl_mask;

  function automatic logic [5:0] ecc(input logic [23:0] h);
    ecc[0] = ^(h & 24'hF12CB7);
    ecc[1] = ^(h & 24'hF2555B);
    ecc[2] = ^(h & 24'h749A6D);
    ecc[3] = ^(h & 24'hB8E38E);
    ecc[4] = ^(h & 24'hDF03F0);
    ecc[5] = ^(h & 24'hEFFC00);
  endfunction

  assign slot_free       = !valid_q || bus.ready_i;
  assign bus.req_ready_o = !rst_i && (state_q == S_IDLE) && slot_free;
  assign bus.pl_ready_o  = !rst_i && (state_q == S_PAYLOAD) && slot_free;
  assign req_acc         = bus.req_valid_i && bus.req_ready_o;
  assign pl_acc          = bus.pl_valid_i && bus.pl_ready_o;

  // Short packets (DT 0x00-0x0F) carry no payload regardless of wc.
  assign wc_sum = {1'b0, bus.wc_i} + 17'd3;
  assign words  = (bus.dt_i[5:4] == 2'b00) ? 15'd0 : wc_sum[16:2];
  assign hdr_lo = {bus.wc_i, bus.vc_i, bus.dt_i};

  always_comb begin
    hdr = {2'b00, ecc(hdr_lo), hdr_lo};
`ifdef CSI2_HDR_ERR_INJECT_EN
    if (bus.inject_i && (bus.inject_bit_i < 5'd30))
      hdr = hdr ^ (32'd1 << bus.inject_bit_i);
`endif
  end

  always_comb begin
    case (wc_lo_q)
      2'd1:    pl_mask = 32'h0000_00FF;
      2'd2:    pl_mask = 32'h0000_FFFF;
      2'd3:    pl_mask = 32'h00FF_FFFF;
      default: pl_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wc_lo_d = wc_lo_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    // A draining slot with nothing new behind it goes empty.
    if (slot_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (req_acc) begin
      data_d  = hdr;
      valid_d = 1'b1;
      wc_lo_d = bus.wc_i[1:0];
      rem_d   = words;
      if (words == 15'd0) begin
        last_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        last_d  = 1'b0;
        state_d = S_PAYLOAD;
      end
    end else if (pl_acc) begin
      valid_d = 1'b1;
      rem_d   = rem_q - 15'd1;
      if (rem_q == 15'd1) begin
        data_d  = bus.pl_data_i & pl_mask;
        last_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        data_d  = bus.pl_data_i;
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      wc_lo_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wc_lo_q <= wc_lo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
endmodule

// File: tb/tb_csi2_pkt_hdr_enc.sv
// Directed bench for csi2_pkt_hdr_enc: header-only vector table plus long-packet,
// backpressure, back-to-back, reset-abort, max word count and injection sequences.
module tb_csi2_pkt_hdr_enc;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  csi2_pkt_hdr_enc_if u_if();
  csi2_pkt_hdr_enc dut (.clk_i(clk_i), .rst_i(rst_i), .bus(u_if));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
    logic [31:0] hdr;
  } hvec_t;
  hvec_t vecs[6];

  logic [31:0] w16 [4];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_req(input string nm, input logic [5:0] dt, input logic [1:0] vc,
                          input logic [15:0] wc, input logic [31:0] hdr, input logic exp_last);
    int t = 0;
    u_if.dt_i = dt; u_if.vc_i = vc; u_if.wc_i = wc; u_if.req_valid_i = 1'b1;
    #1;
    while (u_if.req_ready_o !== 1'b1 && t < 20) begin tick(); t++; end
    chk({nm, "_req_ready"}, {31'd0, u_if.req_ready_o}, 32'd1);
    tick();
    // Fields changing after acceptance must not affect the packet.
    u_if.req_valid_i = 1'b0; u_if.dt_i = 6'h00; u_if.wc_i = 16'hDEAD;
    chk({nm, "_hdr"},  u_if.data_o, hdr);
    chk({nm, "_vld"},  {31'd0, u_if.valid_o}, 32'd1);
    chk({nm, "_last"}, {31'd0, u_if.last_o}, {31'd0, exp_last});
  endtask

  task automatic push(input string nm, input logic [31:0] w, input logic [31:0] exp,
                      input logic exp_last);
    int t = 0;
    u_if.pl_data_i = w; u_if.pl_valid_i = 1'b1;
    #1;
    while (u_if.pl_ready_o !== 1'b1 && t < 20) begin tick(); t++; end
    chk({nm, "_pl_ready"}, {31'd0, u_if.pl_ready_o}, 32'd1);
    tick();
    u_if.pl_valid_i = 1'b0;
    chk({nm, "_data"}, u_if.data_o, exp);
    chk({nm, "_vld"},  {31'd0, u_if.valid_o}, 32'd1);
    chk({nm, "_last"}, {31'd0, u_if.last_o}, {31'd0, exp_last});
  endtask

  task automatic push4(input string nm);
    for (int k = 0; k < 4; k++) push(nm, w16[k], w16[k], k == 3);
  endtask

  initial begin
    int bad;
    logic [31:0] w, e;
    vecs[0] = '{6'h00, 2'd0, 16'h0001, 32'h1A00_0100};
    vecs[1] = '{6'h01, 2'd0, 16'h0000, 32'h0700_0001};
    vecs[2] = '{6'h00, 2'd1, 16'h0000, 32'h1600_0040};
    vecs[3] = '{6'h2B, 2'd0, 16'h0000, 32'h1700_002B};
    vecs[4] = '{6'h12, 2'd3, 16'h0000, 32'h1700_00D2};
    vecs[5] = '{6'h0F, 2'd2, 16'hFFFF, 32'h2CFF_FF8F};
    w16[0] = 32'h0302_0100; w16[1] = 32'h0706_0504;
    w16[2] = 32'h0B0A_0908; w16[3] = 32'h0F0E_0D0C;

    u_if.req_valid_i = 0; u_if.dt_i = 0; u_if.vc_i = 0; u_if.wc_i = 0;
    u_if.pl_data_i = 0; u_if.pl_valid_i = 0; u_if.ready_i = 1'b1;
`ifdef CSI2_HDR_ERR_INJECT_EN
    u_if.inject_i = 1'b0; u_if.inject_bit_i = 5'd0;
`endif

    rst_i = 1'b1;
    tick(); tick();
    chk("rst_data",      u_if.data_o, 32'd0);
    chk("rst_valid",     {31'd0, u_if.valid_o}, 32'd0);
    chk("rst_last",      {31'd0, u_if.last_o}, 32'd0);
    chk("rst_req_ready", {31'd0, u_if.req_ready_o}, 32'd0);
    chk("rst_pl_ready",  {31'd0, u_if.pl_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, u_if.req_ready_o}, 32'd1);

    // Header-only packets, issued back to back.
    for (int i = 0; i < 6; i++) send_req($sformatf("vec%0d", i), vecs[i].dt, vecs[i].vc,
                                         vecs[i].wc, vecs[i].hdr, 1'b1);
    tick();
    chk("drain_valid", {31'd0, u_if.valid_o}, 32'd0);

    // Long packet, with a request attempt stalled during payload.
    send_req("long16", 6'h2B, 2'd0, 16'h0010, 32'h3100_102B, 1'b0);
    u_if.req_valid_i = 1'b1;
    #1;
    chk("payload_req_stall", {31'd0, u_if.req_ready_o}, 32'd0);
    u_if.req_valid_i = 1'b0;
    push4("long16");

    // Partial last word masking uses the latched wc.
    send_req("part", 6'h2B, 2'd0, 16'h0005, 32'h2E00_052B, 1'b0);
    push("part0", 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
    push("part1", 32'hBBBB_BBBB, 32'h0000_00BB, 1'b1);

    // Backpressure mid-payload.
    send_req("bp", 6'h2B, 2'd0, 16'h0010, 32'h3100_102B, 1'b0);
    push("bp0", w16[0], w16[0], 1'b0);
    u_if.ready_i = 1'b0; u_if.pl_data_i = w16[1]; u_if.pl_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data", u_if.data_o, w16[0]);
      chk("bp_hold_vld",  {31'd0, u_if.valid_o}, 32'd1);
      chk("bp_hold_last", {31'd0, u_if.last_o}, 32'd0);
      chk("bp_pl_ready",  {31'd0, u_if.pl_ready_o}, 32'd0);
    end
    u_if.ready_i = 1'b1;
    for (int k = 1; k < 4; k++) push("bp", w16[k], w16[k], k == 3);

    // Two short packets on consecutive cycles.
    send_req("b2b_a", 6'h00, 2'd0, 16'h0001, 32'h1A00_0100, 1'b1);
    send_req("b2b_b", 6'h01, 2'd0, 16'h0000, 32'h0700_0001, 1'b1);

    // Reset during the second payload cycle aborts the packet.
    send_req("abort", 6'h2B, 2'd0, 16'h0010, 32'h3100_102B, 1'b0);
    push("abort0", w16[0], w16[0], 1'b0);
    u_if.pl_data_i = w16[1]; u_if.pl_valid_i = 1'b1; rst_i = 1'b1;
    tick();
    chk("abort_valid", {31'd0, u_if.valid_o}, 32'd0);
    chk("abort_data",  u_if.data_o, 32'd0);
    rst_i = 1'b0; u_if.pl_valid_i = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, u_if.req_ready_o}, 32'd1);
    chk("abort_pl_ready",  {31'd0, u_if.pl_ready_o}, 32'd0);
    send_req("after_abort", 6'h00, 2'd0, 16'h0001, 32'h1A00_0100, 1'b1);

    // Maximum word count: 0x4000 payload words, 3-byte last word.
    send_req("wcmax", 6'h2B, 2'd0, 16'hFFFF, 32'h2DFF_FF2B, 1'b0);
    bad = 0;
    for (int j = 0; j < 16384; j++) begin
      w = {16'hC0DE, 16'(j)};
      e = (j == 16383) ? (w & 32'h00FF_FFFF) : w;
      u_if.pl_data_i = w; u_if.pl_valid_i = 1'b1;
      tick();
      if (u_if.valid_o !== 1'b1 || u_if.data_o !== e || u_if.last_o !== (j == 16383)) bad++;
    end
    chk("wcmax_words_bad", bad, 32'd0);
    #1;
    chk("idle_pl_ignored", {31'd0, u_if.pl_ready_o}, 32'd0);
    u_if.pl_valid_i = 1'b0;

`ifdef CSI2_HDR_ERR_INJECT_EN
    u_if.inject_i = 1'b1; u_if.inject_bit_i = 5'd0;
    send_req("inj0", 6'h2B, 2'd0, 16'h0010, 32'h3100_102A, 1'b0);
    u_if.inject_i = 1'b0;
    push4("inj0");
    u_if.inject_i = 1'b1; u_if.inject_bit_i = 5'd30;
    send_req("inj30", 6'h2B, 2'd0, 16'h0010, 32'h3100_102B, 1'b0);
    u_if.inject_i = 1'b0;
    push4("inj30");
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
